// File: rtl/ptp_stamp_counter.sv
// PTP time-of-day counter: 64.24 fixed-point ns time advanced by a programmable
// increment every clock, with set/adjust/atomic-read through a simple register port.
`timescale 1ns/1ps
module ptp_stamp_counter #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stamp_reg_req,
  input  logic                      stamp_reg_rd_wr_L,
  input  logic [REG_ADDR_WIDTH-1:0] stamp_reg_addr,
  input  logic [31:0]               stamp_reg_wr_data,
  output logic [31:0]               stamp_reg_rd_data,
  output logic                      stamp_reg_ack,
  output logic [COUNTER_WIDTH-1:0]  counter_val
);

  localparam logic [2:0] A_TIME_LO = 3'd0;
  localparam logic [2:0] A_TIME_HI = 3'd1;
  localparam logic [2:0] A_INC     = 3'd2;
  localparam logic [2:0] A_SET_LO  = 3'd3;
  localparam logic [2:0] A_SET_HI  = 3'd4;
  localparam logic [2:0] A_ADJ     = 3'd5;
  localparam logic [2:0] A_CTRL    = 3'd6;

  localparam logic [31:0] INC_RESET = 32'h0800_0000;

  logic [63:0] time_ns;
  logic [23:0] time_frac;
  logic [31:0] inc;
  logic [31:0] set_lo;
  logic [31:0] hi_snap;
  logic        ctrl_en;

  logic [31:0]        addr_ext;
  logic [2:0]         reg_sel;
  logic               reg_hit;
  logic               accept;
  logic               wr_en;
  logic               rd_en;
  logic [87:0]        tod;
  logic [87:0]        step;
  logic [87:0]        next_tod;
  logic signed [31:0] adj_ns;
  logic signed [63:0] adj_ext;
  logic [31:0]        rd_mux;

  // Full 88-bit sum; the carry out of bit 87 is dropped so the time wraps.
  function automatic logic [87:0] tod_add(input logic [87:0] a, input logic [87:0] b);
    return a + b;
  endfunction

  always_comb begin
    addr_ext = 32'(stamp_reg_addr);
    reg_sel  = addr_ext[2:0];
    reg_hit  = (addr_ext[31:3] == 29'd0);
    accept   = stamp_reg_req & ~stamp_reg_ack;
    wr_en    = accept & ~stamp_reg_rd_wr_L & reg_hit;
    rd_en    = accept & stamp_reg_rd_wr_L;
  end

  // Next time: a set overrides the increment; an adjust rides on top of it.
  always_comb begin
    tod     = {time_ns, time_frac};
    step    = ctrl_en ? {56'd0, inc} : 88'd0;
    adj_ns  = signed'(stamp_reg_wr_data);
    adj_ext = 64'(adj_ns);
    if (wr_en && reg_sel == A_SET_HI)
      next_tod = {stamp_reg_wr_data, set_lo, 24'd0};
    else if (wr_en && reg_sel == A_ADJ)
      next_tod = tod_add(tod_add(tod, step), {adj_ext, 24'd0});
    else
      next_tod = tod_add(tod, step);
  end

  always_comb begin
    rd_mux = 32'd0;
    if (reg_hit) begin
      case (reg_sel)
        A_TIME_LO: rd_mux = time_ns[31:0];
        A_TIME_HI: rd_mux = hi_snap;
        A_INC:     rd_mux = inc;
        A_SET_LO:  rd_mux = set_lo;
        A_CTRL:    rd_mux = {31'd0, ctrl_en};
        default:   rd_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_ns           <= 64'd0;
      time_frac         <= 24'd0;
      inc               <= INC_RESET;
      set_lo            <= 32'd0;
      hi_snap           <= 32'd0;
      ctrl_en           <= 1'b1;
      stamp_reg_ack     <= 1'b0;
      stamp_reg_rd_data <= 32'd0;
    end else begin
      {time_ns, time_frac} <= next_tod;
      stamp_reg_ack        <= accept;
      if (wr_en) begin
        case (reg_sel)
          A_INC:    inc     <= stamp_reg_wr_data;
          A_SET_LO: set_lo  <= stamp_reg_wr_data;
          A_CTRL:   ctrl_en <= stamp_reg_wr_data[0];
          default:  ;
        endcase
      end
      if (rd_en) begin
        stamp_reg_rd_data <= rd_mux;
        // Upper word is frozen at the TIME_LO read so a later TIME_HI read pairs with it.
        if (reg_hit && reg_sel == A_TIME_LO)
          hi_snap <= time_ns[63:32];
      end
    end
  end

  assign counter_val = time_ns[COUNTER_WIDTH-1:0];

endmodule

// File: tb/tb_ptp_stamp_counter.sv
// Bench for ptp_stamp_counter: register vector table, scoreboarded read data,
// and hand-written sequences for wrap, atomic read, adjust, fraction carry and reset.
`timescale 1ns/1ps
module tb_ptp_stamp_counter;

  logic        clk;
  logic        reset;
  logic        req;
  logic        rd_wr_L;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic [31:0] counter_val;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          rd;
    logic [2:0]  addr;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  sb_t         sb_e;
  logic [31:0] last_rd = 32'd0;
  vec_t        vecs[17];
  logic [31:0] cv;

  ptp_stamp_counter #(.COUNTER_WIDTH(32), .REG_ADDR_WIDTH(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .stamp_reg_req     (req),
    .stamp_reg_rd_wr_L (rd_wr_L),
    .stamp_reg_addr    (addr),
    .stamp_reg_wr_data (wr_data),
    .stamp_reg_rd_data (rd_data),
    .stamp_reg_ack     (ack),
    .counter_val       (counter_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every ack pops one expectation; reads compare data, writes must leave rd_data untouched.
  always @(negedge clk) begin
    if (reset && ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_ack: got ack=1 expected no pending access");
      end else begin
        sb_e = sb.pop_front();
        if (sb_e.rd) begin
          if (rd_data !== sb_e.exp) begin
            errors++;
            $display("FAIL rd_addr%0d: got %0h expected %0h", sb_e.addr, rd_data, sb_e.exp);
          end
          last_rd = sb_e.exp;
        end else if (rd_data !== last_rd) begin
          errors++;
          $display("FAIL rd_hold_wr_addr%0d: got %0h expected %0h", sb_e.addr, rd_data, last_rd);
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge two clocks later with counter_val from the ack cycle.
  task automatic access(input bit rd, input logic [2:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, output logic [31:0] cv_ack);
    sb_t e;
    bit  got;
    e.rd = rd; e.addr = a; e.exp = exp;
    sb.push_back(e);
    req = 1'b1; rd_wr_L = rd; addr = a; wr_data = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    cv_ack = counter_val;
    req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_addr%0d: got no ack expected ack", a);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{0, 3'd3, 32'h1234_5678, 32'h0};
    vecs[1]  = '{1, 3'd3, 32'h0,         32'h1234_5678};
    vecs[2]  = '{0, 3'd2, 32'h0A00_0000, 32'h0};
    vecs[3]  = '{1, 3'd2, 32'h0,         32'h0A00_0000};
    vecs[4]  = '{0, 3'd2, 32'h0800_0000, 32'h0};
    vecs[5]  = '{1, 3'd2, 32'h0,         32'h0800_0000};
    vecs[6]  = '{1, 3'd4, 32'h0,         32'h0};
    vecs[7]  = '{1, 3'd5, 32'h0,         32'h0};
    vecs[8]  = '{0, 3'd7, 32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1, 3'd7, 32'h0,         32'h0};
    vecs[10] = '{1, 3'd6, 32'h0,         32'h1};
    vecs[11] = '{0, 3'd6, 32'hFFFF_FFFE, 32'h0};
    vecs[12] = '{1, 3'd6, 32'h0,         32'h0};
    vecs[13] = '{0, 3'd6, 32'h0000_0001, 32'h0};
    vecs[14] = '{1, 3'd6, 32'h0,         32'h1};
    vecs[15] = '{0, 3'd1, 32'h5555_5555, 32'h0};
    vecs[16] = '{1, 3'd1, 32'h0,         32'h0};

    reset = 1'b0; req = 1'b0; rd_wr_L = 1'b1; addr = 3'd0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_counter", 64'(counter_val), 64'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("default_inc_10clk", 64'(counter_val), 64'd80);

    foreach (vecs[i]) access(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp, cv);

    // 64-bit wrap: set to all-ones minus 7, one increment later time is 0.
    access(0, 3'd3, 32'hFFFF_FFF8, 0, cv);
    access(0, 3'd4, 32'hFFFF_FFFF, 0, cv);
    check("set_ack_cycle", 64'(cv), 64'hFFFF_FFF8);
    check("wrap_to_zero", 64'(counter_val), 64'd0);
    access(1, 3'd0, 0, 32'h0, cv);
    access(1, 3'd1, 0, 32'h0, cv);

    // Atomic read across a low-word rollover.
    access(0, 3'd6, 32'h0, 0, cv);
    access(0, 3'd3, 32'hFFFF_FFF0, 0, cv);
    access(0, 3'd4, 32'h0000_0001, 0, cv);
    access(1, 3'd0, 0, 32'hFFFF_FFF0, cv);
    access(0, 3'd6, 32'h1, 0, cv);
    check("resume_first_edge", 64'(counter_val), 64'hFFFF_FFF8);
    repeat (20) @(negedge clk);
    access(1, 3'd1, 0, 32'h0000_0001, cv);
    check("running_after_rollover", 64'(cv), 64'hA0);
    access(1, 3'd0, 0, 32'h0000_00A8, cv);
    access(1, 3'd1, 0, 32'h0000_0002, cv);

    // Signed adjust while running, then frozen adjust.
    access(0, 3'd3, 32'd992, 0, cv);
    access(0, 3'd4, 32'd0, 0, cv);
    check("set_992", 64'(cv), 64'd992);
    check("time_1000", 64'(counter_val), 64'd1000);
    access(0, 3'd5, 32'hFFFF_FF9C, 0, cv);
    check("adj_minus100", 64'(cv), 64'd908);
    check("adj_resume", 64'(counter_val), 64'd916);
    access(0, 3'd6, 32'h0, 0, cv);
    check("disable_edge", 64'(cv), 64'd924);
    access(0, 3'd5, 32'd50, 0, cv);
    check("adj_plus50_frozen", 64'(cv), 64'd974);
    repeat (5) @(negedge clk);
    check("stays_frozen", 64'(counter_val), 64'd974);

    // Fraction carry: inc = 8 + 2^-12 ns gains exactly 1 ns every 4096 clocks.
    access(0, 3'd3, 32'd0, 0, cv);
    access(0, 3'd4, 32'd0, 0, cv);
    check("set_zero", 64'(cv), 64'd0);
    access(0, 3'd2, 32'h0800_1000, 0, cv);
    access(0, 3'd6, 32'h1, 0, cv);
    check("enable_edge_no_step", 64'(cv), 64'd0);
    check("frac_step1", 64'(counter_val), 64'd8);
    repeat (4094) @(negedge clk);
    check("frac_4095", 64'(counter_val), 64'd32760);
    @(negedge clk);
    check("frac_carry_4096", 64'(counter_val), 64'd32769);

    // Reset asserted while a CTRL write is pending: access is lost.
    req = 1'b1; rd_wr_L = 1'b0; addr = 3'd6; wr_data = 32'h0;
    #2;
    reset = 1'b0;
    sb.delete();
    last_rd = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ack_in_reset", 64'(ack), 64'd0);
    end
    check("rd_data_in_reset", 64'(rd_data), 64'd0);
    req = 1'b0;
    reset = 1'b1;
    check("time_after_reset", 64'(counter_val), 64'd0);
    access(1, 3'd6, 0, 32'h1, cv);
    check("restart_from_zero", 64'(cv), 64'd8);
    access(1, 3'd2, 0, 32'h0800_0000, cv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
